// File: rtl/srlzr_tx_sequencer.sv
// Transmit frame sequencer: drives PISO load/shift and wraps the serial bit in start/stop framing.
// Optional even-parity bit after the data bits is compiled in with `define SRLZR_PARITY_EN.
module srlzr_tx_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] piso_data,
    output logic                  piso_load,
    output logic                  piso_shift,
    input  logic                  piso_bit,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

`ifdef SRLZR_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    state_t          next_state;
    logic [TW-1:0]   tcnt;
    logic [BW-1:0]   bcnt;
    logic            bit_end;
    logic            accept;
`ifdef SRLZR_PARITY_EN
    logic            parity;
`endif

    assign bit_end = (tcnt == T_LAST);
    assign accept  = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A new accept always restarts the bit timer, which is what makes back-to-back frames seamless.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt      <= '0;
            bcnt      <= '0;
            piso_data <= '0;
            piso_load <= 1'b0;
`ifdef SRLZR_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            piso_load <= accept;
            if (accept) begin
                piso_data <= s_data;
                tcnt      <= '0;
                bcnt      <= '0;
`ifdef SRLZR_PARITY_EN
                parity    <= ^s_data;
`endif
            end else if (state != IDLE) begin
                tcnt <= bit_end ? '0 : tcnt + TW'(1);
                if (state == DATA && bit_end) begin
                    bcnt <= (bcnt == B_LAST) ? '0 : bcnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = START;
            START: if (bit_end) next_state = DATA;
            DATA: begin
                if (bit_end && bcnt == B_LAST) begin
`ifdef SRLZR_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef SRLZR_PARITY_EN
            PARITY: if (bit_end) next_state = STOP;
`endif
            STOP:  if (bit_end) next_state = accept ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_ready    = ~rst & ((state == IDLE) | ((state == STOP) & bit_end));
        frame_done = ~rst & (state == STOP) & bit_end;
        piso_shift = (state == DATA) & bit_end;
        busy       = (state != IDLE);
        tx_out     = 1'b1;
        case (state)
            START:  tx_out = 1'b0;
            DATA:   tx_out = piso_bit;
`ifdef SRLZR_PARITY_EN
            PARITY: tx_out = parity;
`endif
            default: tx_out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_srlzr_tx_sequencer.sv
// Self-checking bench for srlzr_tx_sequencer with a behavioural PISO and line-frame model.
// Honours SRLZR_PARITY_EN to expect the extra parity bit.
module tb_srlzr_tx_sequencer;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SRLZR_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [DW-1:0] piso_data;
    logic          piso_load;
    logic          piso_shift;
    logic          piso_bit;
    logic          tx_out;
    logic          busy;
    logic          frame_done;

    logic [DW-1:0] piso_sr;
    int checks = 0;
    int errors = 0;
    int loads  = 0;
    int shifts = 0;
    int dones  = 0;

    srlzr_tx_sequencer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .piso_data(piso_data), .piso_load(piso_load), .piso_shift(piso_shift),
        .piso_bit(piso_bit), .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Stand-in serializer: parallel load, shift right, bit 0 on the serial output.
    always_ff @(posedge clk) begin
        if (rst) piso_sr <= '0;
        else if (piso_load) piso_sr <= piso_data;
        else if (piso_shift) piso_sr <= piso_sr >> 1;
    end
    assign piso_bit = piso_sr[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        loads  += int'(piso_load);
        shifts += int'(piso_shift);
        dones  += int'(frame_done);
    endtask

    // Line level of frame bit k: start, data LSB first, optional parity, stop.
    function automatic logic line_bit(input logic [DW-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DW) return d[k-1];
        if (k == NBITS - 1) return 1'b1;
        return ^d;
    endfunction

    // Called in the accept cycle; returns in the frame's last STOP cycle.
    task automatic run_frame(input logic [DW-1:0] d, input logic nv, input logic [DW-1:0] nd,
                             input logic poke);
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                tick();
                check($sformatf("tx_out[%0h] bit%0d c%0d", d, k, c), 32'(tx_out), 32'(line_bit(d, k)));
                check("busy", 32'(busy), 32'd1);
                check("piso_load", 32'(piso_load), 32'((k == 0) && (c == 0)));
                if (k == NBITS - 1 && c == CPB - 1) begin
                    check("frame_done last", 32'(frame_done), 32'd1);
                    check("s_ready last", 32'(s_ready), 32'd1);
                    check("piso_data end", 32'(piso_data), 32'(d));
                end else begin
                    check("frame_done mid", 32'(frame_done), 32'd0);
                    check("s_ready mid", 32'(s_ready), 32'd0);
                end
                if (k == 0 && c == 0) begin
                    check("piso_data load", 32'(piso_data), 32'(d));
                    s_valid = nv;
                    s_data  = nd;
                end
                if (poke && k == 3 && c == 1) begin
                    s_valid = 1'b1;
                    s_data  = 8'hFF;
                end
                if (poke && k == 3 && c == 2) begin
                    s_valid = nv;
                    s_data  = nd;
                end
            end
        end
    endtask

    task automatic offer(input logic [DW-1:0] d);
        s_data  = d;
        s_valid = 1'b1;
        #1;
        check("s_ready offer", 32'(s_ready), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] w;
        int d0;

        s_valid = 1'b1;
        s_data  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst s_ready", 32'(s_ready), 32'd0);
            check("rst tx_out", 32'(tx_out), 32'd1);
            check("rst busy", 32'(busy), 32'd0);
            check("rst frame_done", 32'(frame_done), 32'd0);
            check("rst piso_data", 32'(piso_data), 32'd0);
            check("rst piso_load", 32'(piso_load), 32'd0);
            check("rst piso_shift", 32'(piso_shift), 32'd0);
        end
        s_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check("post-rst s_ready", 32'(s_ready), 32'd1);
        tick();
        check("post-rst busy", 32'(busy), 32'd0);
        check("post-rst loads", 32'(loads), 32'd0);

        loads = 0; shifts = 0; dones = 0;
        offer(8'hA5);
        run_frame(8'hA5, 1'b0, 8'h00, 1'b0);
        check("single loads", 32'(loads), 32'd1);
        check("single shifts", 32'(shifts), 32'(DW));
        check("single dones", 32'(dones), 32'd1);
        tick();
        check("idle busy", 32'(busy), 32'd0);
        check("idle tx_out", 32'(tx_out), 32'd1);

        offer(8'h3C);
        run_frame(8'h3C, 1'b1, 8'hC3, 1'b0);
        run_frame(8'hC3, 1'b0, 8'h00, 1'b0);
        tick();
        check("b2b idle busy", 32'(busy), 32'd0);

        offer(8'h5E);
        run_frame(8'h5E, 1'b0, 8'h00, 1'b1);
        tick();

        offer(8'h07);
        run_frame(8'h07, 1'b0, 8'h00, 1'b0);
        tick();
        offer(8'h03);
        run_frame(8'h03, 1'b0, 8'h00, 1'b0);
        tick();

        for (int n = 0; n < 6; n++) begin
            w = DW'($urandom);
            offer(w);
            run_frame(w, 1'b0, 8'h00, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
        tick();

        w = 8'h96;
        offer(w);
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 4 * CPB; i++) tick();
        check("mid bit3 tx_out", 32'(tx_out), 32'(w[3]));
        tick();
        d0  = dones;
        rst = 1'b1;
        tick();
        check("abort tx_out", 32'(tx_out), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort frame_done", 32'(frame_done), 32'd0);
        check("abort piso_data", 32'(piso_data), 32'd0);
        rst = 1'b0;
        #1;
        check("abort s_ready", 32'(s_ready), 32'd1);
        check("abort no done", 32'(dones), 32'(d0));

        offer(8'h69);
        run_frame(8'h69, 1'b0, 8'h00, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/srlzr_tx_sequencer.md
# srlzr_tx_sequencer

Frame sequencer that owns the PISO serializer of the transmitter. It accepts parallel words through a valid/ready handshake and drives the serializer's `load`/`shift` controls at the programmed bit rate. It wraps the serializer's serial output in an asynchronous line frame: start bit, DATA_WIDTH data bits LSB first, optional parity, and stop bit. It sits between the transceiver's transmit word source and the line driver.

## Interface
- `DATA_WIDTH`, default 8: word width. Must be ≥ 2.
- `CLKS_PER_BIT`, default 16: clk cycles per line bit. Must be ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  source word valid.
- `s_data`  in  DATA_WIDTH  source word.
- `s_ready`  out  1  sequencer can accept a word.
- `piso_data`  out  DATA_WIDTH  word to parallel-load into the serializer. Held register.
- `piso_load`  out  1  one-cycle serializer load strobe.
- `piso_shift`  out  1  one-cycle serializer shift strobe.
- `piso_bit`  in  1  serializer serial output (its bit 0).
- `tx_out`  out  1  framed serial line, idle high.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `frame_done`  out  1  one-cycle pulse, last cycle of STOP.

## Operation
- **States:** IDLE, START, DATA, PARITY (only with macro), STOP.
- **Registers:**
  - bit timer `tcnt`: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - bit index `bcnt`: 0..DATA_WIDTH-1.
  - word register `piso_data`.
  - parity register.
- **Accept:** a word is accepted when `s_valid & s_ready`. On accept, `piso_data` <= `s_data`, state <= START, `tcnt` <= 0. When the macro is enabled, parity <= ^`s_data`.
- **`s_ready` is combinational:** 1 in IDLE, and 1 in the last STOP cycle (`tcnt == CLKS_PER_BIT-1`). It is 0 otherwise and 0 while `rst` is high.
- **`piso_load`:** registered. It is 1 for exactly the first START cycle, i.e. the cycle after accept.
- **State transitions:** each state lasts CLKS_PER_BIT cycles. `tcnt` wraps to 0 at each bit boundary.
  - START → DATA.
  - DATA repeats for `bcnt` = 0..DATA_WIDTH-1. It leaves after `bcnt == DATA_WIDTH-1`, going to PARITY (macro) or STOP.
  - PARITY → STOP.
  - STOP → START if a word is accepted in its last cycle; otherwise STOP → IDLE.
- **`piso_shift`:** combinational. It is 1 when state == DATA and `tcnt == CLKS_PER_BIT-1`, giving DATA_WIDTH pulses per frame. The serializer advances to the next bit on that edge.
- **`tx_out`:** combinational from state.
  - IDLE: 1. START: 0. DATA: `piso_bit`. PARITY: parity register. STOP: 1.
- **`s_valid` while not ready:** `s_valid` asserted while `s_ready` = 0 is ignored. The word is not captured and the source must hold it.
- **Reset:** reset mid-frame aborts immediately. The state goes to IDLE and every register returns to its reset value. The line returns high on the next cycle. No `frame_done` is generated.

## Timing
- **Reset values:**
  - `s_ready` = 0 during reset, 1 in the first cycle after reset.
  - `piso_data` = 0, `piso_load` = 0, `piso_shift` = 0.
  - `tx_out` = 1, `busy` = 0, `frame_done` = 0.
- **Start latency:** accept in cycle T gives `tx_out` = 0 and `piso_load` = 1 in cycle T+1.
- **Frame length:** (2 + DATA_WIDTH [+1 parity]) × CLKS_PER_BIT cycles, counted from T+1 through the last STOP cycle.
- **Data bit timing:** data bit i appears on `tx_out` from T+1+(1+i)·CLKS_PER_BIT.
- **Back-to-back:** accept in the last STOP cycle gives zero idle cycles between frames. The next START begins the following cycle, and `frame_done` and the accept coincide.
- **`frame_done` and `busy`:**
  - `frame_done` is high in the last STOP cycle only.
  - `busy` falls the cycle after that, unless a new word was accepted.

## Configuration
- **`SRLZR_PARITY_EN` defined:**
  - PARITY state is compiled in.
  - One even-parity bit (XOR of the word) is sent after the data bits.
  - Frame is (3 + DATA_WIDTH) × CLKS_PER_BIT cycles.
- **Undefined:** no PARITY state and no parity register. DATA goes directly to STOP.

## Test plan
- **Reset values:** hold `rst` 3 cycles with `s_valid` = 1 → outputs stay at reset values and nothing is accepted. First cycle after reset: `s_ready` = 1.
- **Single frame** (DATA_WIDTH = 8, CLKS_PER_BIT = 4, model PISO, `s_data` = 0xA5, no parity):
  - `tx_out` = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - Exactly 1 `piso_load` and 8 `piso_shift` pulses.
  - `frame_done` once, at cycle T+40.
- **Back-to-back:** present 0x3C with `s_valid` held high, then 0xC3 → second START begins the cycle after the first frame's last STOP cycle. No high gap beyond the stop bit. `busy` stays 1 throughout.
- **Ignored offer:** pulse `s_valid` with 0xFF mid-frame (`s_ready` = 0) → word not captured. `piso_data` is unchanged and the current frame is unaffected.
- **Reset mid-frame:** assert `rst` during DATA bit 3 → next cycle: `tx_out` = 1, `busy` = 0, no `frame_done`, and `s_ready` = 1 after release.
- **Parity** (`SRLZR_PARITY_EN`, CLKS_PER_BIT = 4): 0x07 → parity bit 1; 0x03 → parity bit 0. Each frame is 44 cycles long.
